alarm_sequencer: RTL and testbench



---
 rtl/alarm_sequencer_if.sv | 30 +++
 rtl/alarm_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_if.sv
// Bundle of time/alarm inputs and player-control outputs for alarm_sequencer.
// The slave modport is the sequencer's view; master is the driver's view.
interface alarm_sequencer_if;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_en;
    logic [1:0] song_sel;
    logic       snooze_btn;
    logic       stop_btn;
    logic       chime_en;
    logic       play;
    logic [1:0] song_id;
    logic       ringing;
    logic [1:0] state_o;

    modport master (
        output cur_hour, cur_min, cur_sec, alarm_hour, alarm_min, alarm_en,
        output song_sel, snooze_btn, stop_btn, chime_en,
        input  play, song_id, ringing, state_o
    );

    modport slave (
        input  cur_hour, cur_min, cur_sec, alarm_hour, alarm_min, alarm_en,
        input  song_sel, snooze_btn, stop_btn, chime_en,
        output play, song_id, ringing, state_o
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm/snooze sequencer driving the song player's enable and tune select.
// The hourly chime is compiled in only when HOURLY_CHIME_EN is defined.
module alarm_sequencer #(
    parameter int unsigned CLK_HZ         = 100000000,
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300,
    parameter int unsigned CHIME_SECONDS  = 4,
    parameter int unsigned MAX_SNOOZE     = 3,
    parameter int unsigned CHIME_SONG     = 1
) (
    input logic              sys_CLK,
    input logic              rst_n,
    alarm_sequencer_if.slave bus
);
    localparam int unsigned DivW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned MaxRs  = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS
                                                                     : SNOOZE_SECONDS;
    localparam int unsigned MaxSec = (MaxRs > CHIME_SECONDS) ? MaxRs : CHIME_SECONDS;
    localparam int unsigned RemW   = (MaxSec > 1) ? $clog2(MaxSec + 1) : 1;
    localparam int unsigned SnzW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRing   = 2'd1,
        StSnooze = 2'd2,
        StChime  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      song_q, song_d;
    logic [SnzW-1:0] snz_cnt_q, snz_cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic [RemW-1:0] rem_q, rem_d;
    logic            play_q, play_d, ringing_q, ringing_d;
    logic            amatch_q, snooze_q, stop_q, live_q;
    logic            amatch, alarm_ev, chime_ev, snooze_ev, stop_ev;
    logic            tick, expire, enter, quit;

    // live_q masks events on the first edge after reset so that a match already
    // present at reset release only primes the edge registers.
    assign amatch    = bus.alarm_en && (bus.cur_hour == bus.alarm_hour) &&
                       (bus.cur_min == bus.alarm_min) && (bus.cur_sec == 6'd0);
    assign alarm_ev  = live_q && amatch && !amatch_q;
    assign snooze_ev = live_q && bus.snooze_btn && !snooze_q;
    assign stop_ev   = live_q && bus.stop_btn && !stop_q;
    assign quit      = stop_ev || !bus.alarm_en;
    assign tick      = (div_q == DivW'(CLK_HZ - 1));
    assign expire    = tick && (rem_q == RemW'(1));

`ifdef HOURLY_CHIME_EN
    logic cmatch, cmatch_q;
    assign cmatch   = bus.chime_en && (bus.cur_min == 6'd0) && (bus.cur_sec == 6'd0);
    assign chime_ev = live_q && cmatch && !cmatch_q;

    always_ff @(posedge sys_CLK or negedge rst_n) begin
        if (!rst_n) cmatch_q <= 1'b0;
        else        cmatch_q <= cmatch;
    end
`else
    assign chime_ev = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        snz_cnt_d = snz_cnt_q;
        enter     = 1'b0;
        if (alarm_ev) begin
            state_d   = StRing;
            song_d    = bus.song_sel;
            snz_cnt_d = '0;
            enter     = 1'b1;
        end else begin
            case (state_q)
                StRing: begin
                    if (quit) begin
                        state_d = StIdle;
                        enter   = 1'b1;
                    end else if (snooze_ev && (snz_cnt_q < SnzW'(MAX_SNOOZE))) begin
                        state_d   = StSnooze;
                        snz_cnt_d = snz_cnt_q + 1'b1;
                        enter     = 1'b1;
                    end else if (expire) begin
                        state_d = StIdle;
                        enter   = 1'b1;
                    end
                end
                StSnooze: begin
                    if (quit) begin
                        state_d = StIdle;
                        enter   = 1'b1;
                    end else if (expire) begin
                        state_d = StRing;
                        enter   = 1'b1;
                    end
                end
`ifdef HOURLY_CHIME_EN
                StChime: begin
                    if (stop_ev || expire) begin
                        state_d = StIdle;
                        enter   = 1'b1;
                    end
                end
`endif
                StIdle: begin
                    if (chime_ev) begin
                        state_d = StChime;
                        song_d  = 2'(CHIME_SONG);
                        enter   = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    enter   = 1'b1;
                end
            endcase
        end
    end

    // Timers restart on every state entry so each period is exactly N*CLK_HZ cycles.
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        rem_d = (tick && (rem_q != '0)) ? rem_q - 1'b1 : rem_q;
        if (enter) begin
            div_d = '0;
            case (state_d)
                StRing:   rem_d = RemW'(RING_SECONDS);
                StSnooze: rem_d = RemW'(SNOOZE_SECONDS);
`ifdef HOURLY_CHIME_EN
                StChime:  rem_d = RemW'(CHIME_SECONDS);
`endif
                default:  rem_d = '0;
            endcase
        end
        play_d    = (state_d == StRing) || (state_d == StChime);
        ringing_d = (state_d == StRing) || (state_d == StSnooze);
    end

    always_ff @(posedge sys_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            song_q    <= 2'd0;
            snz_cnt_q <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            play_q    <= 1'b0;
            ringing_q <= 1'b0;
            amatch_q  <= 1'b0;
            snooze_q  <= 1'b0;
            stop_q    <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            snz_cnt_q <= snz_cnt_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            play_q    <= play_d;
            ringing_q <= ringing_d;
            amatch_q  <= amatch;
            snooze_q  <= bus.snooze_btn;
            stop_q    <= bus.stop_btn;
            live_q    <= 1'b1;
        end
    end

    assign bus.play    = play_q;
    assign bus.song_id = song_q;
    assign bus.ringing = ringing_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: vector table plus hand-written reset sequence,
// with expected outputs queued when stimulus is applied and popped when sampled.
module tb_alarm_sequencer;
    logic sys_CLK = 1'b0;
    logic rst_n;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .CLK_HZ        (10),
        .RING_SECONDS  (3),
        .SNOOZE_SECONDS(2),
        .CHIME_SECONDS (2),
        .MAX_SNOOZE    (1),
        .CHIME_SONG    (1)
    ) dut (
        .sys_CLK(sys_CLK),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 sys_CLK = ~sys_CLK;

`ifdef HOURLY_CHIME_EN
    localparam bit HasChime = 1'b1;
`else
    localparam bit HasChime = 1'b0;
`endif

    typedef struct {
        int         n;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [4:0] ah;
        logic [5:0] am;
        logic       aen;
        logic [1:0] sel;
        logic       snz;
        logic       stp;
        logic       chen;
        logic [5:0] exp;  // {play, song_id, ringing, state_o}
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] sb_q[$];
    int         checks = 0;
    int         errors = 0;

    function automatic vec_t mk(input int n, input int h, input int m, input int s,
                                input int ah, input int am, input bit aen, input int sel,
                                input bit snz, input bit stp, input bit chen,
                                input bit p, input int song, input bit r, input int st);
        vec_t v;
        v.n   = n;
        v.h   = 5'(h);
        v.m   = 6'(m);
        v.s   = 6'(s);
        v.ah  = 5'(ah);
        v.am  = 6'(am);
        v.aen = aen;
        v.sel = 2'(sel);
        v.snz = snz;
        v.stp = stp;
        v.chen = chen;
        v.exp = {p, 2'(song), r, 2'(st)};
        return v;
    endfunction

    task automatic check(input string name);
        logic [5:0] e;
        logic [5:0] a;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        a = {bus.play, bus.song_id, bus.ringing, bus.state_o};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got play=%b song=%0d ring=%b state=%0d, want play=%b song=%0d ring=%b state=%0d",
                     name, a[5], a[4:3], a[2], a[1:0], e[5], e[4:3], e[2], e[1:0]);
        end
    endtask

    // Called at a falling edge; applies inputs, advances n rising edges, samples at the next fall.
    task automatic run(input vec_t v, input string name);
        bus.cur_hour   = v.h;
        bus.cur_min    = v.m;
        bus.cur_sec    = v.s;
        bus.alarm_hour = v.ah;
        bus.alarm_min  = v.am;
        bus.alarm_en   = v.aen;
        bus.song_sel   = v.sel;
        bus.snooze_btn = v.snz;
        bus.stop_btn   = v.stp;
        bus.chime_en   = v.chen;
        sb_q.push_back(v.exp);
        repeat (v.n) @(posedge sys_CLK);
        @(negedge sys_CLK);
        check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cs;
        int cst;
        cs  = HasChime ? 1 : 2;
        cst = HasChime ? 3 : 0;

        rst_n          = 1'b0;
        bus.cur_hour   = '0;
        bus.cur_min    = '0;
        bus.cur_sec    = '0;
        bus.alarm_hour = '0;
        bus.alarm_min  = '0;
        bus.alarm_en   = 1'b0;
        bus.song_sel   = '0;
        bus.snooze_btn = 1'b0;
        bus.stop_btn   = 1'b0;
        bus.chime_en   = 1'b0;
        repeat (2) @(posedge sys_CLK);
        @(negedge sys_CLK);
        sb_q.push_back(6'b0);
        check("reset");
        rst_n = 1'b1;

        // Alarm 07:30, song 2: ring lasts exactly 30 cycles.
        tbl.push_back(mk(1, 7, 29, 59, 7, 30, 1, 2, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(29, 7, 30, 0, 7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  0, 2, 0, 0));
        // Snooze for 20 cycles, back to RING, second snooze ignored, stop.
        tbl.push_back(mk(1, 7, 29, 59, 7, 30, 1, 2, 0, 0, 0,  0, 2, 0, 0));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 1, 0, 0,  0, 2, 1, 2));
        tbl.push_back(mk(19, 7, 30, 0, 7, 30, 1, 2, 0, 0, 0,  0, 2, 1, 2));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 1, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 1, 0,  0, 2, 0, 0));
        tbl.push_back(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  0, 2, 0, 0));
        // Hourly chime at 09:00 with alarm disabled.
        tbl.push_back(mk(1, 8, 59, 59, 7, 30, 0, 2, 0, 0, 1,  0, 2, 0, 0));
        tbl.push_back(mk(1, 9, 0, 0,   7, 30, 0, 2, 0, 0, 1,  HasChime, cs, 0, cst));
        tbl.push_back(mk(19, 9, 0, 0,  7, 30, 0, 2, 0, 0, 1,  HasChime, cs, 0, cst));
        tbl.push_back(mk(1, 9, 0, 0,   7, 30, 0, 2, 0, 0, 1,  0, cs, 0, 0));
        // Alarm at 10:00 with chime enabled: RING wins.
        tbl.push_back(mk(1, 9, 59, 59, 10, 0, 1, 3, 0, 0, 1,  0, cs, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 0, 1, 1,  0, 3, 0, 0));
        tbl.push_back(mk(1, 9, 59, 59, 10, 0, 1, 3, 0, 0, 1,  0, 3, 0, 0));
        // Stop and snooze together: stop wins.
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 1, 1, 1,  0, 3, 0, 0));
        tbl.push_back(mk(1, 9, 59, 59, 10, 0, 1, 3, 0, 0, 1,  0, 3, 0, 0));
        // Disarming the alarm ends RING.
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 0, 3, 0, 0, 1,  0, 3, 0, 0));
        tbl.push_back(mk(1, 9, 59, 59, 10, 0, 1, 3, 0, 0, 1,  0, 3, 0, 0));
        // Alarm event mid-RING restarts a full 30-cycle period.
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(15, 10, 0, 0, 10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(1, 9, 59, 59, 10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(29, 10, 0, 0, 10, 0, 1, 3, 0, 0, 1,  1, 3, 1, 1));
        tbl.push_back(mk(1, 10, 0, 0,  10, 0, 1, 3, 0, 0, 1,  0, 3, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-RING, then no retrigger while the match is held.
        run(mk(1, 7, 29, 59, 7, 30, 1, 2, 0, 0, 0,  0, 3, 0, 0), "pre_ring");
        run(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1), "ring_on");
        run(mk(5, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1), "ring_hold");
        #2 rst_n = 1'b0;
        #1;
        sb_q.push_back(6'b0);
        check("async_reset");
        @(negedge sys_CLK);
        rst_n = 1'b1;
        run(mk(5, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  0, 0, 0, 0), "no_retrigger");
        run(mk(1, 7, 29, 59, 7, 30, 1, 2, 0, 0, 0,  0, 0, 0, 0), "post_idle");
        run(mk(1, 7, 30, 0,  7, 30, 1, 2, 0, 0, 0,  1, 2, 1, 1), "post_ring");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
